// File: rtl/vend_dispenser.sv
// vend_dispenser: queues vend/change events, pulses the product solenoid,
// then pays change coin by coin to a hopper over a req/ack handshake.
module vend_dispenser #(
  parameter int SOL_CYCLES  = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend,
  input  logic [1:0] change,
  output logic       sol,
  output logic       coin10_req,
  output logic       coin5_req,
  input  logic       coin_ack,
  output logic       full,
  output logic       overflow,
  output logic       fault,
  output logic       idle
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (SOL_CYCLES > ACK_TIMEOUT) ? SOL_CYCLES : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] SOL_LAST = CW'(SOL_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOL,
    S_PAY,
    S_WAIT_ACK,
    S_WAIT_REL,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rem_q, rem_d;
  logic          sol_q, sol_d;
  logic          c10_q, c10_d;
  logic          c5_q, c5_d;
  logic          ovf_q, ovf_d;
  logic          fault_q, fault_d;

  logic [2:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic       push;
  logic       push_ok;
  logic       pop;
  logic       empty;
  logic       is_full;
  logic [2:0] rd_data;

  assign empty   = (count_q == '0);
  assign is_full = (count_q == FULL_CNT);
  assign push    = vend | (change != 2'd0);
  // fullness is judged before any same-cycle pop
  assign push_ok = push & ~is_full;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sol_d   = sol_q;
    c10_d   = c10_q;
    c5_d    = c5_q;
    fault_d = fault_q;
    pop     = 1'b0;
    ovf_d   = ovf_q | (push & is_full);
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          rem_d = rd_data[1:0];
          cnt_d = '0;
          if (rd_data[2]) begin
            state_d = S_SOL;
            sol_d   = 1'b1;
          end else begin
            state_d = S_PAY;
          end
        end
      end
      S_SOL: begin
        if (cnt_q == SOL_LAST) begin
          sol_d   = 1'b0;
          state_d = S_PAY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PAY: begin
        cnt_d = '0;
        if (rem_q >= 2'd2) begin
          c10_d   = 1'b1;
          state_d = S_WAIT_ACK;
        end else if (rem_q == 2'd1) begin
          c5_d    = 1'b1;
          state_d = S_WAIT_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        if (coin_ack) begin
          rem_d   = c10_q ? (rem_q - 2'd2) : (rem_q - 2'd1);
          c10_d   = 1'b0;
          c5_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_WAIT_REL;
        end else if (cnt_q == TO_LAST) begin
          c10_d   = 1'b0;
          c5_d    = 1'b0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_REL: begin
        if (!coin_ack) begin
          state_d = S_PAY;
        end else if (cnt_q == TO_LAST) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FAULT: begin
        sol_d = 1'b0;
        c10_d = 1'b0;
        c5_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      sol_q    <= 1'b0;
      c10_q    <= 1'b0;
      c5_q     <= 1'b0;
      ovf_q    <= 1'b0;
      fault_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      sol_q    <= sol_d;
      c10_q    <= c10_d;
      c5_q     <= c5_d;
      ovf_q    <= ovf_d;
      fault_q  <= fault_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {vend, change};
    end
  end

  assign sol        = sol_q;
  assign coin10_req = c10_q;
  assign coin5_req  = c5_q;
  assign full       = is_full;
  assign overflow   = ovf_q;
  assign fault      = fault_q;
  assign idle       = (state_q == S_IDLE) && empty;

endmodule

// File: tb/tb_vend_dispenser.sv
// tb_vend_dispenser: directed checks of solenoid timing, coin
// payout handshake, queue overflow, hopper timeout and reset.
module tb_vend_dispenser;

  logic       clk;
  logic       rst;
  logic       vend;
  logic [1:0] change;
  logic       sol;
  logic       coin10_req;
  logic       coin5_req;
  logic       coin_ack;
  logic       full;
  logic       overflow;
  logic       fault;
  logic       idle;

  int n_assert = 0;
  int n_fail   = 0;

  vend_dispenser dut (
    .clk        (clk),
    .rst        (rst),
    .vend       (vend),
    .change     (change),
    .sol        (sol),
    .coin10_req (coin10_req),
    .coin5_req  (coin5_req),
    .coin_ack   (coin_ack),
    .full       (full),
    .overflow   (overflow),
    .fault      (fault),
    .idle       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b0;
    vend     = 1'b0;
    change   = 2'd0;
    coin_ack = 1'b0;
    tick();
    tick();
    check("rst_idle", idle, 1'b1);
    check("rst_sol", sol, 1'b0);
    check("rst_c10", coin10_req, 1'b0);
    check("rst_c5", coin5_req, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_fault", fault, 1'b0);
    rst = 1'b1;
    tick();
    check("rel_idle", idle, 1'b1);
    check("rel_sol", sol, 1'b0);

    // plain vend, no change
    vend = 1'b1;
    tick();
    vend = 1'b0;
    check("v0_lat_sol", sol, 1'b0);
    check("v0_busy", idle, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("v0_sol_hi", sol, 1'b1);
      check("v0_no_c10", coin10_req, 1'b0);
      check("v0_no_c5", coin5_req, 1'b0);
      tick();
    end
    check("v0_sol_lo", sol, 1'b0);
    check("v0_pay_busy", idle, 1'b0);
    tick();
    check("v0_idle", idle, 1'b1);
    check("v0_c10_lo", coin10_req, 1'b0);
    check("v0_c5_lo", coin5_req, 1'b0);

    // vend with 15 units change: 10 then 5
    vend   = 1'b1;
    change = 2'd3;
    tick();
    vend   = 1'b0;
    change = 2'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("v3_sol_hi", sol, 1'b1);
      check("v3_no_c10", coin10_req, 1'b0);
      tick();
    end
    check("v3_sol_lo", sol, 1'b0);
    check("v3_pay_c10", coin10_req, 1'b0);
    tick();
    check("v3_c10_hi", coin10_req, 1'b1);
    check("v3_c5_lo", coin5_req, 1'b0);
    tick();
    check("v3_c10_hold", coin10_req, 1'b1);
    coin_ack = 1'b1;
    tick();
    check("v3_c10_drop", coin10_req, 1'b0);
    check("v3_c5_rel", coin5_req, 1'b0);
    tick();
    check("v3_rel_c10", coin10_req, 1'b0);
    check("v3_rel_c5", coin5_req, 1'b0);
    coin_ack = 1'b0;
    tick();
    check("v3_pay2_c5", coin5_req, 1'b0);
    tick();
    check("v3_c5_hi", coin5_req, 1'b1);
    check("v3_c10_lo", coin10_req, 1'b0);
    coin_ack = 1'b1;
    tick();
    check("v3_c5_drop", coin5_req, 1'b0);
    coin_ack = 1'b0;
    tick();
    check("v3_pay3_busy", idle, 1'b0);
    tick();
    check("v3_idle", idle, 1'b1);
    check("v3_end_c5", coin5_req, 1'b0);

    // stalled hopper: queue fills, overflows, then timeout
    change = 2'd1;
    tick();
    change = 2'd0;
    check("st_c5_t0", coin5_req, 1'b0);
    tick();
    check("st_c5_pay", coin5_req, 1'b0);
    tick();
    check("st_c5_hi", coin5_req, 1'b1);
    vend = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 5) vend = 1'b0;
      check("st_c5_hold", coin5_req, 1'b1);
      if (i <= 5) begin
        check("st_full", full, i >= 4);
        check("st_ovf", overflow, i >= 5);
      end
    end
    check("st_no_fault", fault, 1'b0);
    tick();
    check("to_fault", fault, 1'b1);
    check("to_c5_lo", coin5_req, 1'b0);
    check("to_c10_lo", coin10_req, 1'b0);
    check("to_sol_lo", sol, 1'b0);
    check("to_full", full, 1'b1);
    check("to_ovf", overflow, 1'b1);
    check("to_busy", idle, 1'b0);
    coin_ack = 1'b1;
    tick();
    tick();
    coin_ack = 1'b0;
    tick();
    check("to_sticky", fault, 1'b1);
    check("to_ack_ign", coin5_req, 1'b0);
    check("to_no_pop", full, 1'b1);

    // reset clears fault state
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("r1_fault", fault, 1'b0);
    check("r1_ovf", overflow, 1'b0);
    check("r1_full", full, 1'b0);
    check("r1_idle", idle, 1'b1);

    // reset during WAIT_ACK with two events queued
    change = 2'd2;
    tick();
    change = 2'd0;
    tick();
    tick();
    check("r2_c10_hi", coin10_req, 1'b1);
    vend = 1'b1;
    tick();
    tick();
    vend = 1'b0;
    check("r2_q_full", full, 1'b0);
    check("r2_q_busy", idle, 1'b0);
    check("r2_c10_wait", coin10_req, 1'b1);
    rst = 1'b0;
    tick();
    check("r2_c10_lo", coin10_req, 1'b0);
    check("r2_idle", idle, 1'b1);
    check("r2_full", full, 1'b0);
    check("r2_sol", sol, 1'b0);
    rst = 1'b1;
    tick();
    check("r2_disc_idle", idle, 1'b1);
    check("r2_disc_sol", sol, 1'b0);
    tick();
    check("r2_disc_sol2", sol, 1'b0);
    check("r2_disc_c10", coin10_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
